// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide controller with HI/LO registers and pipeline stall generation.
// An op is issued from IDLE, counts down for a fixed number of cycles, then writes HI/LO.
module mult_div_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  output logic [2:0]  busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMult, StDiv} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // Product: extend per signedness, then the low 64 bits of the product are exact.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = mul_a * mul_b;

  // Division on magnitudes; signs restored afterwards (0x80000000 / -1 wraps naturally).
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  assign a_neg = sgn_q & a_q[31];
  assign b_neg = sgn_q & b_q[31];
  assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
  assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
  assign q_mag = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
  assign r_mag = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
  assign quo   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OpMult);
              cnt_d   = MultLoad;
              state_d = StMult;
            end
            OpDiv, OpDivu: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OpDiv);
              cnt_d   = DivLoad;
              state_d = StDiv;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StMult: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = StIdle;
        end
      end
      StDiv: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  logic issue;
  assign issue = start && (state_q == StIdle) && (op >= OpMult) && (op <= OpDivu);

  assign busy      = {state_q == StDiv, state_q == StMult, issue};
  assign stall_req = (rd_hilo && (busy != 3'b000)) || (start && (state_q != StIdle));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
